// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU micro-op sequencer slice:
//   - opcode class codes (upper four bits of an instruction opcode)
//   - fixed ALU opcodes produced by the translator (8-bit, zero-extended
//     by users to their opcode width)
//   - sequencer state encoding
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    // Opcode class codes, taken from opcode[OP_W-1 -: 4]
    localparam logic [3:0] CLS_RTYPE = 4'h0;
    localparam logic [3:0] CLS_JMP   = 4'h4;
    localparam logic [3:0] CLS_SHIFT = 4'h8;
    localparam logic [3:0] CLS_BCOND = 4'hC;
    localparam logic [3:0] CLS_LUI   = 4'hF;

    // Function codes inside the jump class that collapse to ADDU
    localparam logic [3:0] FN_JAL    = 4'hC;
    localparam logic [3:0] FN_JMP    = 4'h8;
    localparam logic [3:0] FN_JMPR   = 4'hF;

    // Fixed ALU opcodes
    localparam logic [7:0] ADDU_OP   = 8'h06;
    localparam logic [7:0] JMPR_OP   = 8'h4F;

    // Sequencer states
    //   IDLE   : nothing held on the output
    //   SINGLE : holding a single micro-op or the last one of a sequence
    //   EXP1   : holding the first micro-op of an expanded jump-and-link
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        EXP1   = 2'd2
    } seq_state_e;

endpackage : alu_ctrl_pkg

// File: rtl/alu_uop_sequencer_decode.sv
// ---------------------------------------------------------------------------
// alu_op_decode
// Purely combinational opcode-to-ALU-opcode translator.
//
// Ports:
//   opcode  in  OP_W  fetched instruction opcode
//   alu_op  out OP_W  translated ALU opcode
//   is_jal  out 1     opcode equals the jump-and-link opcode JAL_OP
//
// Class field is opcode[OP_W-1 -: 4], function field is opcode[3:0].
// ---------------------------------------------------------------------------
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned          OP_W   = 8,
    parameter logic [OP_W-1:0]      JAL_OP = OP_W'(8'h4C)
) (
    input  logic [OP_W-1:0] opcode,
    output logic [OP_W-1:0] alu_op,
    output logic            is_jal
);

    logic [3:0] cls_s;
    logic [3:0] fn_s;

    assign cls_s  = opcode[OP_W-1 -: 4];
    assign fn_s   = opcode[3:0];
    assign is_jal = (opcode == JAL_OP);

    // Class/function mapping onto the ALU opcode space
    always_comb begin
        alu_op = opcode;
        case (cls_s)
            CLS_RTYPE: begin
                alu_op = opcode;
            end
            CLS_JMP: begin
                if ((fn_s == FN_JAL) || (fn_s == FN_JMP)) begin
                    alu_op = OP_W'(ADDU_OP);
                end else if (fn_s == FN_JMPR) begin
                    alu_op = OP_W'(JMPR_OP);
                end else begin
                    alu_op = opcode;
                end
            end
            CLS_SHIFT: begin
                alu_op = opcode;
            end
            CLS_BCOND: begin
                alu_op = OP_W'(ADDU_OP);
            end
            CLS_LUI: begin
                alu_op = opcode;
            end
            default: begin
                // Immediate-type: only the class value survives, in the low nibble
                alu_op = OP_W'(cls_s);
            end
        endcase
    end

endmodule : alu_op_decode

// File: rtl/alu_uop_sequencer.sv
// ---------------------------------------------------------------------------
// alu_uop_sequencer
// Sits between decode and ALU issue. Translates each accepted opcode into
// one ALU micro-op (or two for jump-and-link when EXPAND_EN=1), holds it
// behind a valid/ready handshake, and counts completed output handshakes.
//
// Ports:
//   clock         in   1      rising-edge clock for all state
//   reset         in   1      synchronous, active-high, highest priority
//   flush         in   1      synchronous kill of held/pending micro-ops
//   in_valid      in   1      opcode valid
//   in_ready      out  1      opcode accepted this cycle when in_valid=1
//   opcode        in   OP_W   instruction opcode
//   out_valid     out  1      alu_opcode valid
//   out_ready     in   1      ALU stage takes the micro-op
//   alu_opcode    out  OP_W   translated ALU opcode (stale while !out_valid)
//   uop_sel_link  out  1      micro-op uses the PC/link operand path
//   uop_last      out  1      final micro-op of the current instruction
//   uop_count     out  CNT_W  completed output handshakes, wraps
// ---------------------------------------------------------------------------
module alu_uop_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned     OP_W      = 8,
    parameter bit              EXPAND_EN = 1'b1,
    parameter logic [OP_W-1:0] JAL_OP    = OP_W'(8'h4C),
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  alu_opcode,
    output logic             uop_sel_link,
    output logic             uop_last,
    output logic [CNT_W-1:0] uop_count
);

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    seq_state_e        state_q,     state_d;
    logic              out_valid_q, out_valid_d;
    logic [OP_W-1:0]   alu_op_q,    alu_op_d;
    logic              sel_link_q,  sel_link_d;
    logic              last_q,      last_d;
    logic [CNT_W-1:0]  count_q,     count_d;

    // -----------------------------------------------------------------------
    // Translation
    // -----------------------------------------------------------------------
    logic [OP_W-1:0]   dec_op_s;
    logic              dec_is_jal_s;

    alu_op_decode #(
        .OP_W   (OP_W),
        .JAL_OP (JAL_OP)
    ) u_decode (
        .opcode (opcode),
        .alu_op (dec_op_s),
        .is_jal (dec_is_jal_s)
    );

    // -----------------------------------------------------------------------
    // Handshake qualifiers
    // -----------------------------------------------------------------------
    logic accept_s;
    logic fire_s;
    logic expand_s;

    // The second half of an expanded JAL blocks new input; otherwise a slot
    // frees up whenever the held micro-op is empty or leaving this cycle.
    assign in_ready = !reset && !flush && (state_q != EXP1) &&
                      (!out_valid_q || out_ready);
    assign accept_s = in_valid && in_ready;
    assign fire_s   = out_valid_q && out_ready;
    assign expand_s = EXPAND_EN && dec_is_jal_s;

    // Next-state, next-output and counter computation
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_op_d    = alu_op_q;
        sel_link_d  = sel_link_q;
        last_d      = last_q;
        count_d     = count_q;

        // A micro-op dropped by flush never completes, so it is not counted
        if (fire_s && !flush) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end

        if (flush) begin
            // alu_opcode keeps its stale value; only valid is cleared
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, SINGLE: begin
                    if (accept_s) begin
                        out_valid_d = 1'b1;
                        if (expand_s) begin
                            // First half of JAL: link-address add
                            alu_op_d   = OP_W'(ADDU_OP);
                            sel_link_d = 1'b1;
                            last_d     = 1'b0;
                            state_d    = EXP1;
                        end else begin
                            alu_op_d   = dec_op_s;
                            sel_link_d = 1'b0;
                            last_d     = 1'b1;
                            state_d    = SINGLE;
                        end
                    end else if (fire_s) begin
                        out_valid_d = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        // Idle with nothing new, or stalled by backpressure
                        state_d = state_q;
                    end
                end
                EXP1: begin
                    if (out_ready) begin
                        // Second half of JAL: target add
                        out_valid_d = 1'b1;
                        alu_op_d    = OP_W'(ADDU_OP);
                        sel_link_d  = 1'b0;
                        last_d      = 1'b1;
                        state_d     = SINGLE;
                    end else begin
                        state_d = EXP1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_op_q    <= '0;
            sel_link_q  <= 1'b0;
            last_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_op_q    <= alu_op_d;
            sel_link_q  <= sel_link_d;
            last_q      <= last_d;
            count_q     <= count_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign alu_opcode   = alu_op_q;
    assign uop_sel_link = sel_link_q;
    assign uop_last     = last_q;
    assign uop_count    = count_q;

endmodule : alu_uop_sequencer

// File: doc/alu_uop_sequencer.md
Name: alu_uop_sequencer

Overview:
Parametrised successor to the registered ALU opcode translator. It maps fetched instruction opcodes onto ALU opcodes, using the same class mapping as the current controller. It adds a valid/ready handshake on both sides, flush support and a micro-op counter. When EXPAND_EN=1, a jump-and-link opcode is expanded into a two-micro-op sequence: a link-address add followed by a target add. Sits between decode and the ALU issue stage.

Parameters:
OP_W, 8, opcode width (even, >= 8); class field = opcode[OP_W-1 -: 4], function field = opcode[3:0]
EXPAND_EN, 1, 1 = JAL_OP expands into two micro-ops; 0 = JAL_OP maps to a single ADDU_OP
JAL_OP, 'h4C, opcode (zero-extended to OP_W) that triggers expansion
CNT_W, 16, width of issued-micro-op counter

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
flush  input  1  synchronous kill of held/pending micro-ops
in_valid  input  1  opcode valid
in_ready  output  1  sequencer accepts opcode this cycle
opcode  input  OP_W  instruction opcode
out_valid  output  1  alu_opcode valid
out_ready  input  1  ALU stage accepts micro-op
alu_opcode  output  OP_W  translated ALU opcode
uop_sel_link  output  1  micro-op selects PC/link operand path
uop_last  output  1  final micro-op of the current instruction
uop_count  output  CNT_W  count of completed output handshakes, wraps

Behaviour:
- Reset (synchronous, priority over all): out_valid=0, alu_opcode=0, uop_sel_link=0, uop_last=0, uop_count=0, state=IDLE. in_ready=0 while reset is high.
- Translation (combinational, in the decode sub-module):
  - class 0 (RTYPE): pass through.
  - class 4, function 0xC or 0x8: ADDU_OP ('h06).
  - class 4, function 0xF: JMPR_OP ('h4F).
  - class 4, any other function: pass through.
  - class 8 (shift): pass through.
  - class C (bcond): ADDU_OP.
  - class F (LUI): pass through.
  - any other class (ITYPE): class value in bits [3:0], all other bits 0.
  - Constants are zero-extended to OP_W.
- States:
  - IDLE: nothing held.
  - SINGLE: holding a single or last micro-op.
  - EXP1: holding the first micro-op of an expanded JAL.
- in_ready = !reset && !flush && state!=EXP1 && (!out_valid || out_ready).
- Accept (in_valid && in_ready): the translated micro-op is registered and visible next cycle with out_valid=1. Latency is 1 cycle.
  - If EXPAND_EN=1 and opcode==JAL_OP: alu_opcode=ADDU_OP, uop_sel_link=1, uop_last=0, next state EXP1.
  - Otherwise: uop_sel_link=0, uop_last=1, next state SINGLE.
- EXP1 with out_ready=1: next cycle alu_opcode=ADDU_OP, uop_sel_link=0, uop_last=1, state SINGLE. No input is accepted in EXP1.
- SINGLE with out_ready=1:
  - If a new accept happens in the same cycle, load it; out_valid stays 1 (throughput 1 micro-op/cycle).
  - Otherwise out_valid=0, state IDLE.
- Backpressure: while out_valid && !out_ready, all outputs stay stable.
- flush (below reset, above everything else): next cycle out_valid=0, state IDLE. A pending second micro-op is dropped. No input is accepted in the flush cycle. The held micro-op is not counted.
- uop_count: +1 on each out_valid && out_ready && !flush && !reset. Wraps 2^CNT_W-1 -> 0.
- Reset while in EXP1: the sequence is abandoned and the second micro-op is never emitted.
- alu_opcode retains its last value when out_valid=0. Consumers ignore it in that state.

Decomposition:
- Package alu_ctrl_pkg:
  - class codes CLS_RTYPE=4'h0, CLS_JMP=4'h4, CLS_SHIFT=4'h8, CLS_BCOND=4'hC, CLS_LUI=4'hF.
  - ADDU_OP='h06, JMPR_OP='h4F.
  - state enum {IDLE, SINGLE, EXP1}.
- Sub-module alu_op_decode: combinational OP_W-in / OP_W-out mapping, plus an is_jal output. Instantiated once. The sequencer holds all registers.

Test Plan:
- Reset, then opcode 'h23 with out_ready=1 -> next cycle out_valid=1, alu_opcode='h02, uop_last=1, uop_count=1 one cycle later.
- EXPAND_EN=1, opcode 'h4C, out_ready=1:
  - cycle+1: 'h06, sel_link=1, last=0, in_ready=0.
  - cycle+2: 'h06, sel_link=0, last=1.
  - uop_count +2.
- Opcode 'h85 with out_ready=0 for 3 cycles -> alu_opcode='h85 held stable, in_ready=0, uop_count unchanged; then out_ready=1 -> count +1.
- Flush asserted in EXP1 of 'h4C -> next cycle out_valid=0, second micro-op never appears, uop_count unchanged. Same check with reset asserted in EXP1.
- Back-to-back 'h01, 'hC3, 'hF7, 'h4F with out_ready=1 -> consecutive outputs 'h01, 'h06, 'hF7, 'h4F, no bubbles, uop_count=4.
- CNT_W=2, EXPAND_EN=0, five single micro-ops including 'h4C -> 'h4C yields one 'h06 with last=1; uop_count wraps to 1.
